if_prefetch_unit: RTL

Instruction-fetch front end that sits directly upstream of the decode stage and replaces the bare NPC/IF_ID_IR fetch registers. It issues word-addressed requests to a one-cycle-latency instruction memory and buffers the returned words with their NPC in a small prefetch FIFO. It presents instructions to decode with a valid/ready handshake. A branch redirect from execute flushes the FIFO and restarts fetch at the new PC.

---
 rtl/if_prefetch_unit_pkg.sv | 21 ++
 rtl/if_sync_fifo.sv | 63 ++++++
 rtl/if_prefetch_unit.sv | 94 +++++++++
 3 files changed

// File: rtl/if_prefetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch prefetch unit.
package if_prefetch_unit_pkg;

    localparam int unsigned XLEN = 32;  // instruction and PC width
    localparam int unsigned AW   = 5;   // IMEM word-address width

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

    // Major opcode classes, ir[31:26]
    localparam logic [5:0] AR_TYPE = 6'b000000;
    localparam logic [5:0] M_TYPE  = 6'b000001;
    localparam logic [5:0] BR_TYPE = 6'b000010;
    localparam logic [5:0] SH_TYPE = 6'b000011;

    // One buffered fetch: instruction word and the PC of the following word
    typedef struct packed {
        logic [XLEN-1:0] ir;
        logic [XLEN-1:0] npc;
    } fetch_entry_t;

endpackage

// File: rtl/if_sync_fifo.sv
// Synchronous FIFO with registered storage and a synchronous flush.
// Ports: clk, rst (sync, active-high), push/din, pop/dout (head entry),
//        flush (drops all entries), count, full, empty.
module if_sync_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally at DEPTH; flush wins over push and pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/if_prefetch_unit.sv
// Instruction-fetch front end: issues word requests to a 1-cycle IMEM,
// buffers returned words with their NPC, and hands them to decode.
// Ports: clk, RN (sync reset, active-high),
//        imem_req/imem_addr/imem_rdata  - instruction memory interface,
//        redir_en/redir_pc              - branch redirect from execute,
//        id_valid/id_ready/id_ir/id_npc - decode handshake,
//        fetch_pc                       - next PC to be requested.
module if_prefetch_unit
    import if_prefetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic            clk,
    input  logic            RN,
    output logic            imem_req,
    output logic [AW-1:0]   imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redir_en,
    input  logic [XLEN-1:0] redir_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_ir,
    output logic [XLEN-1:0] id_npc,
    output logic [XLEN-1:0] fetch_pc
);

    localparam int unsigned CW  = $clog2(DEPTH) + 1;
    localparam int unsigned CW1 = CW + 1;

    logic [XLEN-1:0] pc;
    logic            inflight;
    logic            started;    // low for the first cycle after reset
    logic [CW-1:0]   count;
    logic            fifo_full;
    logic            fifo_empty;
    logic            credit_ok;
    logic            push;
    logic            pop;
    fetch_entry_t    push_entry;
    fetch_entry_t    head;

    // Occupancy plus the outstanding response must leave room for one more.
    assign credit_ok = (({1'b0, count} + CW1'(inflight)) < CW1'(DEPTH)) && !fifo_full;
    assign imem_req  = started && !RN && !redir_en && credit_ok;
    assign imem_addr = pc[AW-1:0];
    assign fetch_pc  = pc;

    // pc was already advanced at issue, so it equals the responding word's NPC.
    assign push           = inflight && !redir_en;
    assign push_entry.ir  = imem_rdata;
    assign push_entry.npc = pc;
    assign pop            = id_valid && id_ready;

    assign id_valid = !fifo_empty;
    assign id_ir    = head.ir;
    assign id_npc   = head.npc;

    // PC and in-flight tracking; a redirect drops the outstanding response.
    always_ff @(posedge clk) begin
        if (RN) begin
            pc       <= '0;
            inflight <= 1'b0;
            started  <= 1'b0;
        end else begin
            started <= 1'b1;
            if (redir_en) begin
                pc       <= redir_pc;
                inflight <= 1'b0;
            end else begin
                inflight <= imem_req;
                if (imem_req) begin
                    pc <= pc + XLEN'(1);
                end
            end
        end
    end

    if_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk   (clk),
        .rst   (RN),
        .push  (push),
        .pop   (pop),
        .flush (redir_en),
        .din   (push_entry),
        .dout  (head),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule
